// File: rtl/cep_link_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : cep_link_serializer                                           |
// | Purpose  : Takes one full-width CEP package per valid/ready handshake    |
// |            and streams its first pkg_nflits words onto the inter-chip    |
// |            link as LINK_WIDTH flits, least-significant word first.       |
// |            The link has no backpressure wire; a local credit counter     |
// |            mirrors the receiver buffer and gates every flit.            |
// | Ports    : clk, rst_n         - clock, async active-low reset             |
// |            pkg_data/nflits   - package payload and flit count (0 = max)  |
// |            pkg_valid/ready   - package handshake (ready is combinational)|
// |            link_data/valid/last - registered flit outputs                |
// |            link_credit       - one-cycle credit return pulse             |
// |            credit_count      - current credits (debug)                   |
// |            credit_overflow   - sticky: credit returned while full        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module cep_link_serializer #(
  parameter int PKG_WIDTH  = 512,
  parameter int LINK_WIDTH = 64,
  parameter int MAX_FLITS  = PKG_WIDTH / LINK_WIDTH,
  parameter int NFLITS_W   = $clog2(MAX_FLITS),
  parameter int CREDITS    = 8,
  parameter int CNT_W      = $clog2(CREDITS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [PKG_WIDTH-1:0]  pkg_data,
  input  logic [NFLITS_W-1:0]   pkg_nflits,
  input  logic                  pkg_valid,
  output logic                  pkg_ready,
  output logic [LINK_WIDTH-1:0] link_data,
  output logic                  link_valid,
  output logic                  link_last,
  input  logic                  link_credit,
  output logic [CNT_W-1:0]      credit_count,
  output logic                  credit_overflow
);

  // rem spans 1..MAX_FLITS, so it needs one bit more than the nflits field.
  localparam int                REM_W    = NFLITS_W + 1;
  localparam logic [REM_W-1:0]  REM_ONE  = REM_W'(1);
  localparam logic [REM_W-1:0]  REM_MAX  = REM_W'(MAX_FLITS);
  localparam logic [CNT_W-1:0]  CRED_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CRED_MAX = CNT_W'(CREDITS);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t               state_q;
  logic [PKG_WIDTH-1:0] sreg_q;
  logic [REM_W-1:0]     rem_q;
  logic [CNT_W-1:0]     credit_q;
  logic [LINK_WIDTH-1:0] link_data_q;
  logic                 link_valid_q;
  logic                 link_last_q;
  logic                 overflow_q;

  logic                 send;
  logic                 accept;
  logic [REM_W-1:0]     rem_load_d;

  // A send depends only on registered credits, so a returned credit cannot
  // reach the flit path in the same cycle.
  assign send   = (state_q == SEND) && (credit_q != '0);
  // Ready during the final flit's send cycle lets packages run back to back.
  assign pkg_ready = (state_q == IDLE) || (send && (rem_q == REM_ONE));
  assign accept = pkg_valid && pkg_ready;
  assign rem_load_d = (pkg_nflits == '0) ? REM_MAX : {1'b0, pkg_nflits};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sreg_q       <= '0;
      rem_q        <= REM_ONE;
      credit_q     <= CRED_MAX;
      link_data_q  <= '0;
      link_valid_q <= 1'b0;
      link_last_q  <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      if (send) begin
        link_valid_q <= 1'b1;
        link_data_q  <= sreg_q[LINK_WIDTH-1:0];
        link_last_q  <= (rem_q == REM_ONE);
        sreg_q       <= sreg_q >> LINK_WIDTH;
        rem_q        <= rem_q - REM_ONE;
        if (rem_q == REM_ONE) begin
          state_q <= IDLE;
        end
      end else begin
        // link_data deliberately holds its last value while idle/stalled.
        link_valid_q <= 1'b0;
        link_last_q  <= 1'b0;
      end

      // A new package overrides the shift/return-to-idle of the last flit.
      if (accept) begin
        sreg_q  <= pkg_data;
        rem_q   <= rem_load_d;
        state_q <= SEND;
      end

      case ({send, link_credit})
        2'b10: credit_q <= credit_q - CRED_ONE;
        2'b01: begin
          if (credit_q == CRED_MAX) begin
            overflow_q <= 1'b1;
          end else begin
            credit_q <= credit_q + CRED_ONE;
          end
        end
        default: ;  // none, or send and return cancel out
      endcase
    end
  end

  assign link_data       = link_data_q;
  assign link_valid      = link_valid_q;
  assign link_last       = link_last_q;
  assign credit_count    = credit_q;
  assign credit_overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_cep_link_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_cep_link_serializer                                        |
// | Purpose  : Directed self-checking bench for cep_link_serializer.         |
// |            Inputs change 1 time unit after each rising edge; outputs     |
// |            are checked at that same point.                               |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_cep_link_serializer;

  localparam int PKG_WIDTH  = 512;
  localparam int LINK_WIDTH = 64;
  localparam int NFLITS_W   = 3;
  localparam int CNT_W      = 4;

  logic                  clk;
  logic                  rst_n;
  logic [PKG_WIDTH-1:0]  pkg_data;
  logic [NFLITS_W-1:0]   pkg_nflits;
  logic                  pkg_valid;
  logic                  pkg_ready;
  logic [LINK_WIDTH-1:0] link_data;
  logic                  link_valid;
  logic                  link_last;
  logic                  link_credit;
  logic [CNT_W-1:0]      credit_count;
  logic                  credit_overflow;

  int n_cmp = 0;
  int n_err = 0;

  cep_link_serializer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pkg_data        (pkg_data),
    .pkg_nflits      (pkg_nflits),
    .pkg_valid       (pkg_valid),
    .pkg_ready       (pkg_ready),
    .link_data       (link_data),
    .link_valid      (link_valid),
    .link_last       (link_last),
    .link_credit     (link_credit),
    .credit_count    (credit_count),
    .credit_overflow (credit_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Package whose word i is base+i.
  function automatic logic [PKG_WIDTH-1:0] mk(input logic [63:0] base);
    logic [PKG_WIDTH-1:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) p[i*64 +: 64] = base + 64'(i);
    return p;
  endfunction

  task automatic flit(input string tag, input logic [63:0] d, input logic last,
                      input int cred);
    chk({tag, "_valid"}, 64'(link_valid), 64'h1);
    chk({tag, "_data"},  link_data, d);
    chk({tag, "_last"},  64'(link_last), 64'(last));
    chk({tag, "_cred"},  64'(credit_count), 64'(cred));
  endtask

  task automatic refill(input int n);
    link_credit = 1'b1;
    repeat (n) tick();
    link_credit = 1'b0;
  endtask

  logic [63:0] bb_data [6];
  logic        bb_last [6];

  initial begin
    rst_n = 1'b0; pkg_data = '0; pkg_nflits = '0; pkg_valid = 1'b0; link_credit = 1'b0;
    repeat (2) tick();
    chk("rst_valid", 64'(link_valid), 64'h0);
    chk("rst_last",  64'(link_last), 64'h0);
    chk("rst_data",  link_data, 64'h0);
    chk("rst_cred",  64'(credit_count), 64'h8);
    chk("rst_ovf",   64'(credit_overflow), 64'h0);
    chk("rst_ready", 64'(pkg_ready), 64'h1);
    rst_n = 1'b1;
    tick();

    // Full package, words 0..7, ample credits.
    pkg_data = mk(64'h0); pkg_nflits = 3'd0; pkg_valid = 1'b1;
    tick();
    pkg_valid = 1'b0;
    chk("full_lat", 64'(link_valid), 64'h0);
    for (int i = 0; i < 8; i++) begin
      tick();
      flit("full", 64'(i), (i == 7), 7 - i);
    end
    tick();
    chk("full_end_valid", 64'(link_valid), 64'h0);
    chk("full_end_ready", 64'(pkg_ready), 64'h1);
    refill(8);
    chk("refill1", 64'(credit_count), 64'h8);
    chk("refill1_ovf", 64'(credit_overflow), 64'h0);

    // Short package, two flits.
    pkg_data = mk(64'hA0); pkg_nflits = 3'd2; pkg_valid = 1'b1;
    tick();
    pkg_valid = 1'b0;
    chk("short_ready0", 64'(pkg_ready), 64'h0);
    tick();
    flit("short0", 64'hA0, 1'b0, 7);
    chk("short_ready_w1", 64'(pkg_ready), 64'h1);
    tick();
    flit("short1", 64'hA1, 1'b1, 6);
    tick();
    chk("short_end_valid", 64'(link_valid), 64'h0);
    chk("short_end_cred", 64'(credit_count), 64'h6);
    refill(2);

    // Back-to-back packages of 3 flits each.
    bb_data = '{64'hB0, 64'hB1, 64'hB2, 64'hC0, 64'hC1, 64'hC2};
    bb_last = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    pkg_data = mk(64'hB0); pkg_nflits = 3'd3; pkg_valid = 1'b1;
    tick();
    pkg_data = mk(64'hC0);
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 2) pkg_valid = 1'b0;
      flit("b2b", bb_data[i], bb_last[i], 7 - i);
    end
    tick();
    chk("b2b_end_valid", 64'(link_valid), 64'h0);
    refill(6);

    // Credit stall: full package with a second one pending, no returns.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    pkg_data = mk(64'hD0); pkg_nflits = 3'd0; pkg_valid = 1'b1;
    tick();
    pkg_data = mk(64'hE0); pkg_nflits = 3'd1;
    for (int i = 0; i < 8; i++) begin
      tick();
      flit("stall", 64'hD0 + 64'(i), (i == 7), 7 - i);
    end
    pkg_valid = 1'b0;
    tick();
    chk("stall_valid", 64'(link_valid), 64'h0);
    chk("stall_ready", 64'(pkg_ready), 64'h0);
    tick();
    chk("stall_valid2", 64'(link_valid), 64'h0);
    link_credit = 1'b1;
    tick();
    link_credit = 1'b0;
    chk("stall_pulse_valid", 64'(link_valid), 64'h0);
    chk("stall_pulse_cred", 64'(credit_count), 64'h1);
    tick();
    flit("stall_resume", 64'hE0, 1'b1, 0);
    tick();
    chk("stall_after_valid", 64'(link_valid), 64'h0);
    refill(8);

    // Send and return in the same cycle; then overflow.
    pkg_data = mk(64'hF0); pkg_nflits = 3'd4; pkg_valid = 1'b1;
    tick();
    pkg_valid = 1'b0;
    link_credit = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      flit("simul", 64'hF0 + 64'(i), (i == 3), 8);
    end
    chk("simul_ovf0", 64'(credit_overflow), 64'h0);
    tick();
    link_credit = 1'b0;
    chk("ovf_cred", 64'(credit_count), 64'h8);
    chk("ovf_set", 64'(credit_overflow), 64'h1);
    repeat (2) tick();
    chk("ovf_sticky", 64'(credit_overflow), 64'h1);

    // Reset in the middle of a package.
    pkg_data = mk(64'h10); pkg_nflits = 3'd0; pkg_valid = 1'b1;
    tick();
    pkg_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      flit("mid", 64'h10 + 64'(i), 1'b0, 7 - i);
    end
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(link_valid), 64'h0);
    chk("mid_rst_cred", 64'(credit_count), 64'h8);
    chk("mid_rst_ready", 64'(pkg_ready), 64'h1);
    chk("mid_rst_ovf", 64'(credit_overflow), 64'h0);
    tick();
    rst_n = 1'b1;
    pkg_data = mk(64'h20); pkg_nflits = 3'd2; pkg_valid = 1'b1;
    tick();
    pkg_valid = 1'b0;
    tick();
    flit("post0", 64'h20, 1'b0, 7);
    tick();
    flit("post1", 64'h21, 1'b1, 6);
    tick();
    chk("post_end_valid", 64'(link_valid), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
